// File: rtl/hist_acc_bank.sv
// Histogram accumulator bank: 2^bit_bin counters updated read-modify-write at one event per
// cycle, with forwarding, saturating/wrapping add, sticky overflow, readout port and clear sweep.
module hist_acc_bank #(
    parameter int bit_addr_acc = 19,
    parameter int bit_bin      = 8,
    parameter int bit_inc      = 4,
    parameter bit SATURATE     = 1'b1
) (
    input  logic                    clk,
    input  logic                    clr,
    input  logic                    valid_in,
    input  logic [bit_bin-1:0]      bin_in,
    input  logic [bit_inc-1:0]      inc_in,
    output logic                    ready,
    output logic                    busy,
    input  logic                    rd_en,
    input  logic [bit_bin-1:0]      rd_addr,
    output logic                    rd_valid,
    output logic [bit_addr_acc-1:0] rd_data,
    output logic                    ovf
);
    localparam int N  = 1 << bit_bin;
    localparam int SW = bit_addr_acc + 1;

    logic                    busy_q, busy_d;
    logic [bit_bin-1:0]      sweep_addr_q, sweep_addr_d;
    logic                    p1_valid_q, p1_valid_d;
    logic [bit_bin-1:0]      p1_bin_q, p1_bin_d;
    logic [bit_inc-1:0]      p1_inc_q, p1_inc_d;
    logic                    fwd_q, fwd_d;
    logic [bit_addr_acc-1:0] fwd_data_q, fwd_data_d;
    logic                    ovf_q, ovf_d;

    logic [bit_addr_acc-1:0] mem [N];
    logic [bit_addr_acc-1:0] mem_rdata_q;
    logic                    rd_valid_q;
    logic [bit_addr_acc-1:0] rd_data_q;

    logic                    accept;
    logic                    rd_fire;
    logic [bit_addr_acc-1:0] operand;
    logic [SW-1:0]           sum_ext;
    logic                    carry;
    logic [bit_addr_acc-1:0] wr_data;
    logic                    mem_we;
    logic [bit_bin-1:0]      mem_waddr;
    logic [bit_addr_acc-1:0] mem_wdata;

    assign accept  = valid_in && !busy_q && !clr;
    assign rd_fire = rd_en && !busy_q && !clr;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        busy_d       = busy_q;
        sweep_addr_d = sweep_addr_q;
        if (busy_q) begin
            sweep_addr_d = sweep_addr_q + 1'b1;
            if (sweep_addr_q == '1) begin
                busy_d = 1'b0;
            end
        end
    end

    always_comb begin
        operand = fwd_q ? fwd_data_q : mem_rdata_q;
        sum_ext = {1'b0, operand} + SW'(p1_inc_q);
        carry   = sum_ext[SW-1];
        wr_data = sum_ext[bit_addr_acc-1:0];
        if (carry && SATURATE) begin
            wr_data = '1;
        end

        p1_valid_d = accept;
        p1_bin_d   = bin_in;
        p1_inc_d   = inc_in;
        // The event now in P1 writes at the end of this cycle; the next event would read stale data.
        fwd_d      = p1_valid_q && (p1_bin_q == bin_in);
        fwd_data_d = wr_data;
        ovf_d      = ovf_q || (p1_valid_q && carry);

        mem_we    = !clr && (busy_q || p1_valid_q);
        mem_waddr = busy_q ? sweep_addr_q : p1_bin_q;
        mem_wdata = busy_q ? '0 : wr_data;
    end

    // NOTE: sequential state uses non-blocking assignments only, so flops update together.
    always_ff @(posedge clk) begin
        if (clr) begin
            busy_q       <= 1'b1;
            sweep_addr_q <= '0;
            p1_valid_q   <= 1'b0;
            fwd_q        <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            busy_q       <= busy_d;
            sweep_addr_q <= sweep_addr_d;
            p1_valid_q   <= p1_valid_d;
            fwd_q        <= fwd_d;
            ovf_q        <= ovf_d;
        end
        p1_bin_q   <= p1_bin_d;
        p1_inc_q   <= p1_inc_d;
        fwd_data_q <= fwd_data_d;
    end

    // NOTE: the bank itself has no reset; the clear sweep zeroes it so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        mem_rdata_q <= mem[bin_in];
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_fire;
            if (rd_fire) begin
                rd_data_q <= mem[rd_addr];
            end
        end
    end

    assign busy     = busy_q;
    assign ready    = !busy_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign ovf      = ovf_q;

endmodule

// File: tb/tb_hist_acc_bank.sv
// Bench for hist_acc_bank: a default-size bank plus two 4-bit-counter banks (saturating, wrapping)
// checked with vector tables, directed corner sequences and randomized traffic against a model.
module tb_hist_acc_bank;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-size bank
    logic        m_clr, m_valid, m_ready, m_busy, m_rd_en, m_rd_valid, m_ovf;
    logic [7:0]  m_bin, m_rd_addr;
    logic [3:0]  m_inc;
    logic [18:0] m_rd_data;

    // Small banks share all inputs except the increment
    logic       s_clr, s_valid, s_rd_en;
    logic [3:0] s_bin, s_rd_addr, s_inc_sat, s_inc_wrap;
    logic       sat_ready, sat_busy, sat_rd_valid, sat_ovf;
    logic       wrap_ready, wrap_busy, wrap_rd_valid, wrap_ovf;
    logic [3:0] sat_rd_data, wrap_rd_data;

    hist_acc_bank u_main (
        .clk(clk), .clr(m_clr), .valid_in(m_valid), .bin_in(m_bin), .inc_in(m_inc),
        .ready(m_ready), .busy(m_busy), .rd_en(m_rd_en), .rd_addr(m_rd_addr),
        .rd_valid(m_rd_valid), .rd_data(m_rd_data), .ovf(m_ovf)
    );

    hist_acc_bank #(.bit_addr_acc(4), .bit_bin(4), .bit_inc(4), .SATURATE(1'b1)) u_sat (
        .clk(clk), .clr(s_clr), .valid_in(s_valid), .bin_in(s_bin), .inc_in(s_inc_sat),
        .ready(sat_ready), .busy(sat_busy), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_valid(sat_rd_valid), .rd_data(sat_rd_data), .ovf(sat_ovf)
    );

    hist_acc_bank #(.bit_addr_acc(4), .bit_bin(4), .bit_inc(4), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .clr(s_clr), .valid_in(s_valid), .bin_in(s_bin), .inc_in(s_inc_wrap),
        .ready(wrap_ready), .busy(wrap_busy), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
        .rd_valid(wrap_rd_valid), .rd_data(wrap_rd_data), .ovf(wrap_ovf)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic        v;
        logic [7:0]  bin;
        logic [3:0]  inc;
        logic        rd;
        logic [7:0]  ra;
        logic        xv;
        logic [18:0] xd;
    } vec_t;

    typedef struct {
        bit v;
        int bin;
        int inc_a;
        int inc_b;
    } ev_t;

    vec_t        tbl[$];
    int unsigned mm[256];
    int          ms[16];
    int          mw[16];
    bit          ovs, ovw;
    ev_t         pm1, pm2, ps1, ps2;
    int          cm, cs;
    logic [18:0] last_d;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(logic v, logic [7:0] b, logic [3:0] i, logic r, logic [7:0] ra,
                                logic xv, logic [18:0] xd);
        vec_t t;
        t.v = v; t.bin = b; t.inc = i; t.rd = r; t.ra = ra; t.xv = xv; t.xd = xd;
        return t;
    endfunction

    // Waits for both sweeps to end, counting busy cycles; with poke set, offers events and reads
    // to the default bank throughout, all of which must be ignored.
    task automatic wait_sweep(input bit poke, output int cnt_m, output int cnt_s);
        int   guard = 0;
        logic rdy_bad = 1'b0;
        logic rdv_bad = 1'b0;
        cnt_m = 0;
        cnt_s = 0;
        while ((m_busy || sat_busy) && guard < 1000) begin
            if (m_busy) begin
                cnt_m++;
                if (m_ready !== 1'b0) rdy_bad = 1'b1;
            end
            if (m_rd_valid !== 1'b0) rdv_bad = 1'b1;
            if (sat_busy) cnt_s++;
            if (poke) begin
                m_valid   = 1'b1;
                m_bin     = 8'($urandom_range(0, 3));
                m_inc     = 4'($urandom_range(1, 15));
                m_rd_en   = 1'b1;
                m_rd_addr = 8'($urandom_range(0, 255));
            end
            guard++;
            tick();
        end
        m_valid = 1'b0;
        m_rd_en = 1'b0;
        if (m_rd_valid !== 1'b0) rdv_bad = 1'b1;
        check("sweep_bound", 32'(guard < 1000), 32'd1);
        check("ready_low_while_busy", 32'(rdy_bad), 32'd0);
        check("rd_ignored_while_busy", 32'(rdv_bad), 32'd0);
    endtask

    task automatic rd_main(input logic [7:0] a, input logic [18:0] exp, input string name);
        m_rd_en   = 1'b1;
        m_rd_addr = a;
        tick();
        m_rd_en = 1'b0;
        check({name, "_valid"}, 32'(m_rd_valid), 32'd1);
        check(name, 32'(m_rd_data), 32'(exp));
    endtask

    task automatic ev_s(input logic [3:0] b, input logic [3:0] i_sat, input logic [3:0] i_wrap);
        s_valid    = 1'b1;
        s_bin      = b;
        s_inc_sat  = i_sat;
        s_inc_wrap = i_wrap;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic rd_s(input logic [3:0] a, input int exp_sat, input int exp_wrap, input string name);
        s_rd_en   = 1'b1;
        s_rd_addr = a;
        tick();
        s_rd_en = 1'b0;
        check({name, "_sat_valid"}, 32'(sat_rd_valid), 32'd1);
        check({name, "_sat"}, 32'(sat_rd_data), 32'(exp_sat));
        check({name, "_wrap_valid"}, 32'(wrap_rd_valid), 32'd1);
        check({name, "_wrap"}, 32'(wrap_rd_data), 32'(exp_wrap));
    endtask

    // Model update: an event is applied to the reference arrays by its own arithmetic rules.
    task automatic commit_main(input ev_t e);
        if (e.v) mm[e.bin] = mm[e.bin] + e.inc_a;
    endtask

    task automatic commit_small(input ev_t e);
        int t;
        if (e.v) begin
            t = ms[e.bin] + e.inc_a;
            if (t > 15) begin ovs = 1'b1; t = 15; end
            ms[e.bin] = t;
            t = mw[e.bin] + e.inc_b;
            if (t > 15) begin ovw = 1'b1; t = t - 16; end
            mw[e.bin] = t;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m_clr = 1'b1; m_valid = 1'b0; m_bin = '0; m_inc = '0; m_rd_en = 1'b0; m_rd_addr = '0;
        s_clr = 1'b1; s_valid = 1'b0; s_bin = '0; s_inc_sat = '0; s_inc_wrap = '0;
        s_rd_en = 1'b0; s_rd_addr = '0;

        // Power-up clear: one-cycle clr, full-length sweeps
        tick();
        m_clr = 1'b0;
        s_clr = 1'b0;
        check("reset_rd_valid", 32'(m_rd_valid), 32'd0);
        check("reset_rd_data", 32'(m_rd_data), 32'd0);
        check("reset_busy", 32'(m_busy), 32'd1);
        wait_sweep(1'b0, cm, cs);
        check("sweep_len_main", 32'(cm), 32'd256);
        check("sweep_len_small", 32'(cs), 32'd16);
        check("ready_after_sweep", 32'(m_ready), 32'd1);
        rd_main(8'd0, 19'd0, "clear_bin0");
        rd_main(8'd128, 19'd0, "clear_bin128");
        rd_main(8'd255, 19'd0, "clear_bin255");
        check("ovf_after_clear", 32'(m_ovf), 32'd0);

        // Vector table: single event, bursts with forwarding, read-before-write boundaries
        tbl.push_back(mk(1, 5, 3, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 1, 3));
        tbl.push_back(mk(0, 0, 0, 1, 4, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 1, 0));
        for (int i = 0; i < 4; i++) tbl.push_back(mk(1, 7, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 1, 4));
        tbl.push_back(mk(1, 9, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 12, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 9, 1, 6));
        tbl.push_back(mk(0, 0, 0, 1, 12, 1, 2));
        tbl.push_back(mk(1, 7, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 7, 2, 0, 0, 0, 0));
        tbl.push_back(mk(1, 9, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 1, 8));
        tbl.push_back(mk(0, 0, 0, 1, 9, 1, 10));
        tbl.push_back(mk(1, 20, 5, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 20, 1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 20, 1, 5));
        tbl.push_back(mk(1, 20, 1, 1, 20, 1, 5));
        tbl.push_back(mk(0, 0, 0, 1, 20, 1, 5));
        tbl.push_back(mk(0, 0, 0, 1, 20, 1, 6));
        last_d = 19'd0;
        foreach (tbl[i]) begin
            m_valid = tbl[i].v; m_bin = tbl[i].bin; m_inc = tbl[i].inc;
            m_rd_en = tbl[i].rd; m_rd_addr = tbl[i].ra;
            tick();
            check($sformatf("vec%0d_rd_valid", i), 32'(m_rd_valid), 32'(tbl[i].xv));
            if (tbl[i].xv) last_d = tbl[i].xd;
            check($sformatf("vec%0d_rd_data", i), 32'(m_rd_data), 32'(last_d));
        end
        m_valid = 1'b0;
        m_rd_en = 1'b0;
        check("table_ovf", 32'(m_ovf), 32'd0);

        // Small-counter arithmetic: all-ones plus zero, carry via forwarding, sticky flag, clear
        ev_s(4'd4, 4'd15, 4'd15);
        ev_s(4'd4, 4'd0, 4'd0);
        tick(); tick();
        check("allones_plus0_ovf_sat", 32'(sat_ovf), 32'd0);
        check("allones_plus0_ovf_wrap", 32'(wrap_ovf), 32'd0);
        rd_s(4'd4, 15, 15, "allones_plus0");
        ev_s(4'd3, 4'd15, 4'd15);
        ev_s(4'd3, 4'd1, 4'd3);
        ev_s(4'd3, 4'd0, 4'd0);
        tick(); tick();
        check("carry_ovf_sat", 32'(sat_ovf), 32'd1);
        check("carry_ovf_wrap", 32'(wrap_ovf), 32'd1);
        rd_s(4'd3, 15, 2, "carry_result");
        s_clr = 1'b1;
        tick();
        s_clr = 1'b0;
        check("clr_ovf_sat", 32'(sat_ovf), 32'd0);
        check("clr_ovf_wrap", 32'(wrap_ovf), 32'd0);
        wait_sweep(1'b0, cm, cs);
        check("small_resweep_len", 32'(cs), 32'd16);
        rd_s(4'd3, 0, 0, "after_small_clr");

        // clr with three events to bin 1 still in flight; offered events during busy are dropped
        m_valid = 1'b1; m_bin = 8'd1; m_inc = 4'd7;
        tick(); tick(); tick();
        m_valid = 1'b0;
        m_clr = 1'b1;
        tick();
        m_clr = 1'b0;
        check("midstream_rd_valid", 32'(m_rd_valid), 32'd0);
        wait_sweep(1'b1, cm, cs);
        check("midstream_sweep_len", 32'(cm), 32'd256);
        for (int b = 0; b < 4; b++) rd_main(8'(b), 19'd0, $sformatf("dropped_bin%0d", b));

        // clr reasserted while the sweep is at bin 100 restarts a full sweep
        m_clr = 1'b1;
        tick();
        m_clr = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        m_clr = 1'b1;
        tick();
        m_clr = 1'b0;
        wait_sweep(1'b1, cm, cs);
        check("restart_sweep_len", 32'(cm), 32'd256);
        rd_main(8'd1, 19'd0, "restart_bin1");

        // Randomized traffic against the model; fresh clear of every bank first
        m_clr = 1'b1; s_clr = 1'b1;
        tick();
        m_clr = 1'b0; s_clr = 1'b0;
        wait_sweep(1'b0, cm, cs);
        foreach (mm[i]) mm[i] = 0;
        foreach (ms[i]) begin ms[i] = 0; mw[i] = 0; end
        ovs = 1'b0; ovw = 1'b0;
        pm1 = '{0, 0, 0, 0}; pm2 = pm1; ps1 = pm1; ps2 = pm1;
        for (int k = 0; k < 1500; k++) begin
            ev_t em, es;
            int  xm, xs, xw;
            logic rm, rs;
            // Events accepted two or more cycles ago are visible to this cycle's reads
            commit_main(pm2);
            commit_small(ps2);
            em.v     = ($urandom_range(0, 3) != 0);
            em.bin   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7);
            em.inc_a = $urandom_range(0, 15);
            em.inc_b = 0;
            es.v     = ($urandom_range(0, 3) != 0);
            es.bin   = $urandom_range(0, 15);
            es.inc_a = $urandom_range(0, 15);
            es.inc_b = $urandom_range(0, 15);
            rm = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            m_valid = em.v; m_bin = 8'(em.bin); m_inc = 4'(em.inc_a);
            m_rd_en = rm;
            m_rd_addr = ($urandom_range(0, 1) != 0) ? 8'(em.bin) : 8'($urandom_range(0, 7));
            s_valid = es.v; s_bin = 4'(es.bin); s_inc_sat = 4'(es.inc_a); s_inc_wrap = 4'(es.inc_b);
            s_rd_en = rs;
            s_rd_addr = 4'($urandom_range(0, 15));
            xm = int'(mm[m_rd_addr]);
            xs = ms[s_rd_addr];
            xw = mw[s_rd_addr];
            pm2 = pm1; pm1 = em;
            ps2 = ps1; ps1 = es;
            tick();
            check("rand_main_valid", 32'(m_rd_valid), 32'(rm));
            if (rm) check("rand_main_data", 32'(m_rd_data), 32'(xm));
            check("rand_sat_valid", 32'(sat_rd_valid), 32'(rs));
            if (rs) begin
                check("rand_sat_data", 32'(sat_rd_data), 32'(xs));
                check("rand_wrap_data", 32'(wrap_rd_data), 32'(xw));
            end
        end
        m_valid = 1'b0; m_rd_en = 1'b0; s_valid = 1'b0; s_rd_en = 1'b0;
        commit_main(pm2); commit_main(pm1);
        commit_small(ps2); commit_small(ps1);
        tick(); tick();
        check("rand_ovf_main", 32'(m_ovf), 32'd0);
        check("rand_ovf_sat", 32'(sat_ovf), 32'(ovs));
        check("rand_ovf_wrap", 32'(wrap_ovf), 32'(ovw));
        check("rand_ready", 32'(m_ready), 32'd1);
        for (int b = 0; b < 256; b++) rd_main(8'(b), 19'(mm[b]), "final_main");
        for (int b = 0; b < 16; b++) rd_s(4'(b), ms[b], mw[b], "final_small");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
